word_array_ctrl: RTL and testbench

- Access sequencer directly upstream of a bank of Wordcell word stores; turns a valid/ready request (read or write, address, data) into correctly ordered sel_x / op / in_bus strobes.
- Drives one one-hot select line per word, captures the shared out_bus on reads, and returns a response through a valid/ready handshake.
- Sits between the processor-side request logic and the word array.

---
 rtl/word_array_ctrl.sv | 153 +++++++++++++++
 tb/tb_word_array_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/word_array_ctrl.sv
// Access sequencer for a bank of word stores: turns a valid/ready request into
// ordered sel_x / op / in_bus strobes and returns a registered response.
module word_array_ctrl #(
   parameter int unsigned NUM_WORDS    = 4,
   parameter int unsigned ADDR_W       = 2,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned WRITE_CYCLES = 2,
   parameter int unsigned READ_CYCLES  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [DATA_W-1:0]    req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_W-1:0]    rsp_rdata,
   output logic                 rsp_err,
   output logic [NUM_WORDS-1:0] sel_x,
   output logic                 op,
   output logic [DATA_W-1:0]    in_bus,
   input  logic [DATA_W-1:0]    out_bus
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, READ, RESP} state_t;

   state_t               state, state_n;
   logic                 we_q, we_n;
   logic [ADDR_W-1:0]    addr_q, addr_n;
   logic [DATA_W-1:0]    wdata_q, wdata_n;
   logic [CNT_W-1:0]     cnt_q, cnt_n;
   logic [NUM_WORDS-1:0] sel_n;
   logic                 op_n;
   logic [DATA_W-1:0]    in_bus_n;
   logic                 rsp_valid_n;
   logic [DATA_W-1:0]    rsp_rdata_n;
   logic                 rsp_err_n;
   logic                 addr_ok;
   logic [NUM_WORDS-1:0] sel_hot;

   assign req_ready = (state == IDLE) && !rst;
   assign addr_ok   = 32'(addr_q) < NUM_WORDS;
   assign sel_hot   = NUM_WORDS'(1) << addr_q;

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         sel_x     <= '0;
         op        <= 1'b0;
         in_bus    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_n;
         we_q      <= we_n;
         addr_q    <= addr_n;
         wdata_q   <= wdata_n;
         cnt_q     <= cnt_n;
         sel_x     <= sel_n;
         op        <= op_n;
         in_bus    <= in_bus_n;
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rsp_rdata_n;
         rsp_err   <= rsp_err_n;
      end
   end

   // Next state and next output values; sel_n defaults low so select is
   // only raised while sitting in WRITE/READ with op and in_bus already stable.
   always_comb begin
      state_n     = state;
      we_n        = we_q;
      addr_n      = addr_q;
      wdata_n     = wdata_q;
      cnt_n       = cnt_q;
      sel_n       = '0;
      op_n        = op;
      in_bus_n    = in_bus;
      rsp_valid_n = rsp_valid;
      rsp_rdata_n = rsp_rdata;
      rsp_err_n   = rsp_err;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_n  = SETUP;
               we_n     = req_we;
               addr_n   = req_addr;
               wdata_n  = req_wdata;
               op_n     = req_we;
               in_bus_n = req_we ? req_wdata : '0;
            end
         end
         SETUP: begin
            cnt_n = '0;
            if (!addr_ok) begin
               state_n     = RESP;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b1;
               op_n        = 1'b0;
               in_bus_n    = '0;
            end else begin
               state_n = we_q ? WRITE : READ;
               sel_n   = sel_hot;
            end
         end
         WRITE: begin
            if (cnt_q == CNT_W'(WRITE_CYCLES - 1)) begin
               state_n = HOLD;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
               sel_n = sel_hot;
            end
         end
         HOLD: begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            op_n        = 1'b0;
            in_bus_n    = '0;
         end
         READ: begin
            if (cnt_q == CNT_W'(READ_CYCLES - 1)) begin
               state_n     = RESP;
               rsp_valid_n = 1'b1;
               rsp_rdata_n = out_bus;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
               sel_n = sel_hot;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_n     = IDLE;
               rsp_valid_n = 1'b0;
               rsp_err_n   = 1'b0;
               rsp_rdata_n = '0;
               cnt_n       = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_word_array_ctrl.sv
// Scoreboard bench for word_array_ctrl: directed requests push expected
// responses; a monitor pops and compares each response as it is presented.
module tb_word_array_ctrl;

   localparam int unsigned NW = 3;
   localparam int unsigned AW = 2;
   localparam int unsigned DW = 8;
   localparam int unsigned WC = 2;
   localparam int unsigned RC = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic [NW-1:0] sel_x;
   logic          op;
   logic [DW-1:0] in_bus;
   logic [DW-1:0] out_bus;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t exp_q[$];
   int   total_cnt = 0;
   int   pass_cnt  = 0;
   logic [DW-1:0] mem [NW];

   word_array_ctrl #(
      .NUM_WORDS(NW), .ADDR_W(AW), .DATA_W(DW),
      .WRITE_CYCLES(WC), .READ_CYCLES(RC)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .sel_x(sel_x), .op(op), .in_bus(in_bus), .out_bus(out_bus)
   );

   always #5 clk = ~clk;

   // Word store model behind the shared bus
   initial for (int i = 0; i < int'(NW); i++) mem[i] = '0;
   always @(posedge clk)
      for (int i = 0; i < int'(NW); i++)
         if (sel_x[i] && op) mem[i] <= in_bus;
   always_comb begin
      out_bus = '0;
      for (int i = 0; i < int'(NW); i++)
         if (sel_x[i]) out_bus = mem[i];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
   endtask

   // Monitor: compare each newly presented response against the scoreboard
   logic seen = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) chk("sel_onehot0", 32'($onehot0(sel_x)), 32'd1);
      if (rsp_valid && !seen) begin
         seen = 1'b1;
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
         end
      end else if (!rsp_valid) begin
         seen = 1'b0;
      end
   end

   task automatic run_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp_rdata, input logic exp_err, input int stall);
      int n = 0;
      int lat;
      int sel_last;
      logic [NW-1:0] one;
      logic [NW-1:0] exp_sel;
      lat      = exp_err ? 2 : (we ? 3 + int'(WC) : 2 + int'(RC));
      sel_last = we ? 1 + int'(WC) : 1 + int'(RC);
      one      = NW'(1);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      rsp_ready = (stall == 0);
      exp_q.push_back('{rdata: exp_rdata, err: exp_err});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = ~addr;
      req_wdata = ~wdata;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         exp_sel = (!exp_err && c >= 2 && c <= sel_last) ? (one << addr) : '0;
         chk("sel_x", 32'(sel_x), 32'(exp_sel));
         chk("rsp_valid_timing", 32'(rsp_valid), 32'(c == lat));
         if (!exp_err && we && c < lat) begin
            chk("op_write", 32'(op), 32'd1);
            chk("in_bus_write", 32'(in_bus), 32'(wdata));
         end
         if (!we && c < lat) chk("op_read", 32'(op), 32'd0);
      end
      chk("op_resp", 32'(op), 32'd0);
      chk("in_bus_resp", 32'(in_bus), 32'd0);
      for (int s = 1; s < stall; s++) begin
         @(negedge clk);
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rdata", 32'(rsp_rdata), 32'(exp_rdata));
         chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("idle_after_hs", 32'(req_ready), 32'd1);
      chk("valid_after_hs", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_sel_x", 32'(sel_x), 32'd0);
      chk("rst_op", 32'(op), 32'd0);
      chk("rst_in_bus", 32'(in_bus), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 32'd1);

      run_req(1'b1, 2'd2, 8'hA5, 8'h00, 1'b0, 0);   // write
      run_req(1'b0, 2'd2, 8'h00, 8'hA5, 1'b0, 0);   // read back
      run_req(1'b0, 2'd2, 8'h00, 8'hA5, 1'b0, 4);   // read with stall
      run_req(1'b1, 2'd3, 8'h77, 8'h00, 1'b1, 0);   // out of range write
      run_req(1'b0, 2'd3, 8'h00, 8'h00, 1'b1, 2);   // out of range read, stalled
      run_req(1'b1, 2'd1, 8'h5A, 8'h00, 1'b0, 0);
      run_req(1'b0, 2'd1, 8'h00, 8'h5A, 1'b0, 0);

      // Reset during the second cycle of a write
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 2'd0;
      req_wdata = 8'h11;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_sel_before", 32'(sel_x), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_sel", 32'(sel_x), 32'd0);
      chk("midrst_op", 32'(op), 32'd0);
      chk("midrst_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready_after", 32'(req_ready), 32'd1);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);

      run_req(1'b1, 2'd0, 8'h3C, 8'h00, 1'b0, 0);   // back-to-back pair
      run_req(1'b0, 2'd0, 8'h00, 8'h3C, 1'b0, 0);
      run_req(1'b0, 2'd2, 8'h00, 8'hA5, 1'b0, 0);   // survived reset

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
